instruction_fetch_unit: RTL and testbench

Sequencing controller for the byte-addressed, combinational-read instruction memory. Owns the program counter, drives the memory address, and captures each returned 32-bit instruction, with its PC, into a small prefetch queue. Decode drains the queue through a valid/ready handshake. Branch/jump redirects from execute flush the queue. Address faults stop fetching until the next redirect.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and the fetch-address legality check for the
// instruction fetch unit and its prefetch queue.
package fetch_pkg;

   localparam int PC_W       = 64;
   localparam int INST_W     = 32;
   localparam int INST_BYTES = 4;

   localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } fetch_entry_t;

   // Written as pc <= size-4 rather than pc+3 <= size-1 so a pc near 2^64 cannot wrap into range.
   function automatic logic pc_legal(input logic [PC_W-1:0] pc,
                                     input logic [PC_W-1:0] mem_bytes);
      logic w_fits;
      w_fits = (mem_bytes >= PC_W'(INST_BYTES)) &&
               (pc <= (mem_bytes - PC_W'(INST_BYTES)));
      return (pc[1:0] == 2'b00) && w_fits;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {inst, pc} pairs; the head is read
// straight from storage so downstream valid/data never depend on pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = INST_W + PC_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] wdata,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rd_ptr];

   // Popping an empty queue is a no-op; a full queue accepts a push only alongside a pop.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program-counter sequencer: fetches from a combinational instruction memory
// into a prefetch queue, handles redirects and halts on illegal fetch addresses.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              MEM_BYTES = 88,
   parameter int              DEPTH     = 2,
   parameter logic [PC_W-1:0] RESET_PC  = 64'h0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic              fault
);

   localparam logic [PC_W-1:0] MEM_SIZE = PC_W'(MEM_BYTES);

   fetch_state_t    r_state;
   fetch_state_t    w_state_next;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_next;
   logic            r_fault;
   logic            w_fault_next;

   logic         w_push;
   logic         w_flush;
   logic         w_pop;
   logic         w_full;
   logic         w_empty;
   logic         w_redirect_ok;
   logic         w_pc_ok;
   fetch_entry_t w_wdata;
   fetch_entry_t w_head;

   assign w_redirect_ok = pc_legal(redirect_pc, MEM_SIZE);
   assign w_pc_ok       = pc_legal(r_pc, MEM_SIZE);
   assign w_pop         = !w_empty && out_ready;
   assign w_wdata       = '{inst: imem_data, pc: r_pc};

   fetch_queue #(
      .DEPTH (DEPTH),
      .W     (INST_W + PC_W)
   ) u_queue (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .flush (w_flush),
      .wdata (w_wdata),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_fault <= w_fault_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_fault_next = r_fault;
      w_push       = 1'b0;
      w_flush      = 1'b0;

      // A redirect wins in either state and always discards whatever is queued.
      if (redirect_valid) begin
         w_flush   = 1'b1;
         w_pc_next = redirect_pc;
         if (w_redirect_ok) begin
            w_state_next = FETCH;
            w_fault_next = 1'b0;
         end else begin
            w_state_next = HALTED;
            w_fault_next = 1'b1;
         end
      end else begin
         unique case (r_state)
            FETCH: begin
               if (!w_pc_ok) begin
                  w_state_next = HALTED;
                  w_fault_next = 1'b1;
               end else if (!w_full || w_pop) begin
                  w_push    = 1'b1;
                  w_pc_next = r_pc + PC_W'(INST_BYTES);
               end
            end
            HALTED: begin
               w_fault_next = 1'b1;
            end
            default: begin
               w_state_next = FETCH;
            end
         endcase
      end
   end

   assign imem_addr = r_pc;
   assign fault     = r_fault;
   assign out_valid = !w_empty;
   assign out_inst  = w_empty ? NOP_INST : w_head.inst;
   assign out_pc    = w_empty ? RESET_PC : w_head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a 22-word program in a
// combinational memory model.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;
   logic        fault;

   int errors = 0;
   int checks = 0;

   logic [31:0] rom [0:21];

   always #5 clk = ~clk;

   always_comb begin
      if (imem_addr < 64'd88) imem_data = rom[imem_addr[6:2]];
      else                    imem_data = 32'hDEADBEEF;
   end

   instruction_fetch_unit #(
      .MEM_BYTES (88),
      .DEPTH     (2),
      .RESET_PC  (64'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic expect_head(input string tag, input logic [63:0] pc, input logic [31:0] inst);
      check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, "_pc"}, out_pc, pc);
      check({tag, "_inst"}, {32'd0, out_inst}, {32'd0, inst});
      $display("head %s: pc=%h inst=%h", tag, out_pc, out_inst);
   endtask

   task automatic do_reset(input logic rdy);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = rdy;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 22; i++) rom[i] = 32'h1000_0000 + i;
      rom[0]  = 32'h00000913;
      rom[1]  = 32'h00000433;
      rom[2]  = 32'h04b40863;
      rom[14] = 32'hfe0004e3;
      rom[15] = 32'h01a002b3;
      rom[21] = 32'hfa000ae3;

      reset          = 1'b1;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;

      // Reset values
      step();
      check("rst_addr", imem_addr, 64'h0);
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_inst", {32'd0, out_inst}, 64'h13);
      check("rst_pc", out_pc, 64'h0);
      check("rst_fault", {63'd0, fault}, 64'd0);

      // Streaming from reset, one per cycle
      out_ready = 1'b1;
      reset     = 1'b0;
      step(); expect_head("s0", 64'h0, 32'h00000913);
      step(); expect_head("s4", 64'h4, 32'h00000433);
      step(); expect_head("s8", 64'h8, 32'h04b40863);

      // Backpressure: queue fills, pc holds
      do_reset(1'b0);
      repeat (5) step();
      expect_head("hold", 64'h0, 32'h00000913);
      check("hold_addr", imem_addr, 64'h8);
      out_ready = 1'b1;
      step(); expect_head("rel4", 64'h4, 32'h00000433);
      step(); expect_head("rel8", 64'h8, 32'h04b40863);
      step(); expect_head("rel12", 64'hC, 32'h10000003);

      // Redirect flushes queued pcs 4 and 8
      do_reset(1'b0);
      repeat (3) step();
      out_ready = 1'b1;
      step(); expect_head("pre_redir", 64'h4, 32'h00000433);
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h38;
      step();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      check("redir_flush_valid", {63'd0, out_valid}, 64'd0);
      check("redir_addr", imem_addr, 64'h38);
      step(); expect_head("r38", 64'h38, 32'hfe0004e3);
      step(); expect_head("r3c", 64'h3C, 32'h01a002b3);

      // Run to the end of memory; pc 0x58 faults
      for (int k = 'h40; k <= 'h54; k += 4) begin
         step();
         expect_head("seq", 64'(k), (k == 'h54) ? 32'hfa000ae3 : 32'h1000_0000 + 32'(k / 4));
      end
      step();
      check("end_fault", {63'd0, fault}, 64'd1);
      check("end_valid", {63'd0, out_valid}, 64'd0);
      check("end_addr", imem_addr, 64'h58);
      step();
      check("end_fault_sticky", {63'd0, fault}, 64'd1);
      check("end_valid_stays0", {63'd0, out_valid}, 64'd0);

      // Legal redirect recovers from HALTED
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      step();
      redirect_valid = 1'b0;
      check("recover_fault", {63'd0, fault}, 64'd0);
      check("recover_addr", imem_addr, 64'h0);
      step(); expect_head("recover", 64'h0, 32'h00000913);

      // Misaligned redirect
      redirect_valid = 1'b1;
      redirect_pc    = 64'h6;
      step();
      redirect_valid = 1'b0;
      check("mis_fault", {63'd0, fault}, 64'd1);
      check("mis_valid", {63'd0, out_valid}, 64'd0);
      check("mis_addr", imem_addr, 64'h6);
      step();
      check("mis_valid_later", {63'd0, out_valid}, 64'd0);

      // Out-of-range redirect issued from FETCH
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      step();
      check("oor_pre_fault", {63'd0, fault}, 64'd0);
      redirect_pc = 64'h5C;
      step();
      redirect_valid = 1'b0;
      check("oor_fault", {63'd0, fault}, 64'd1);
      check("oor_valid", {63'd0, out_valid}, 64'd0);
      check("oor_addr", imem_addr, 64'h5C);

      // Last legal word is accepted, then the next pc faults
      redirect_valid = 1'b1;
      redirect_pc    = 64'h54;
      step();
      redirect_valid = 1'b0;
      check("last_fault", {63'd0, fault}, 64'd0);
      step(); expect_head("last", 64'h54, 32'hfa000ae3);
      step();
      check("last_next_fault", {63'd0, fault}, 64'd1);

      // Asynchronous reset clears fault without a clock edge
      #1 reset = 1'b1;
      #1;
      check("async_fault_clr", {63'd0, fault}, 64'd0);
      check("async_addr", imem_addr, 64'h0);

      // Reset mid-stream with two queued entries and a simultaneous redirect
      reset = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0;
      out_ready      = 1'b0;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      expect_head("q2", 64'h0, 32'h00000913);
      check("q2_addr", imem_addr, 64'h8);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h38;
      reset          = 1'b1;
      #1;
      check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_fault", {63'd0, fault}, 64'd0);
      check("mid_rst_addr", imem_addr, 64'h0);
      check("mid_rst_inst", {32'd0, out_inst}, 64'h13);
      #1;
      reset          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      step(); expect_head("post_rst", 64'h0, 32'h00000913);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
